// File: rtl/wave_warp_pkg.sv
// Shared types, width helpers and the coordinate wrap used by wave_warp and wave_warp_poly.
package wave_warp_pkg;

   typedef enum logic [1:0] {
      WARP_BYPASS = 2'd0,
      WARP_VERT   = 2'd1,
      WARP_HORZ   = 2'd2,
      WARP_RSVD   = 2'd3
   } warp_mode_e;

   // Signed coordinate width: widest coordinate plus sign and headroom for the root offsets.
   function automatic int coord_w(input int h_w, input int v_w);
      return ((h_w > v_w) ? h_w : v_w) + 2;
   endfunction

   function automatic int prod_w(input int c);
      return 3 * c;
   endfunction

   localparam int COORD_W_DEF = coord_w(11, 10);
   localparam int PROD_W_DEF  = prod_w(COORD_W_DEF);

   // raw always lies in [-m, 3m), so a single correction lands in [0, m-1].
   function automatic int wrap_coord(input int raw, input int m);
      if (raw < 0)
         return raw + m;
      else if (raw >= 2 * m)
         return raw - 2 * m;
      else if (raw >= m)
         return raw - m;
      else
         return raw;
   endfunction

endpackage

// File: rtl/wave_warp_poly.sv
// Stages 1-2 of wave_warp: registers the driver coordinate, forms the cubic
// ((u-ROOT_A)>>>4)*((u-ROOT_B)>>>3)*(u>>>4), applies the amplitude shift and clamps to +/-(mod-1).
module wave_warp_poly
   import wave_warp_pkg::*;
#(
   parameter int C      = COORD_W_DEF,
   parameter int ROOT_A = 320,
   parameter int ROOT_B = 120
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [C-1:0]        u_i,
   input  logic [2:0]          shift_i,
   input  logic [C-1:0]        mod_i,
   output logic signed [C-1:0] pc_o
);

   localparam int P_W = prod_w(C);
   localparam logic signed [C-1:0] ROOT_A_C = C'(ROOT_A);
   localparam logic signed [C-1:0] ROOT_B_C = C'(ROOT_B);

   logic signed [C-1:0]   u_q;
   logic [2:0]            shift_q;
   logic [C-1:0]          mod_q;
   logic signed [C-1:0]   pc_q;

   logic signed [C-1:0]   fa, fb, fc;
   logic signed [P_W-1:0] prod, prod_sh, lim, clamped;
   logic signed [C-1:0]   pc_d;

   always_comb begin
      fa      = (u_q - ROOT_A_C) >>> 4;
      fb      = (u_q - ROOT_B_C) >>> 3;
      fc      = u_q >>> 4;
      prod    = P_W'(fa) * P_W'(fb) * P_W'(fc);
      prod_sh = prod >>> shift_q;
      lim     = P_W'($signed({1'b0, mod_q})) - P_W'(1);
      clamped = prod_sh;
      if (prod_sh > lim)
         clamped = lim;
      else if (prod_sh < -lim)
         clamped = -lim;
      pc_d = C'(clamped);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         u_q     <= '0;
         shift_q <= '0;
         mod_q   <= '0;
         pc_q    <= '0;
      end else begin
         u_q     <= u_i;
         shift_q <= shift_i;
         mod_q   <= mod_i;
         pc_q    <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/wave_warp.sv
// Three-stage cubic coordinate warp with modular wrap; pixel and the other coordinate ride along.
// Optional animated phase compiled in with `define WAVE_WARP_ANIM_EN.
module wave_warp
   import wave_warp_pkg::*;
#(
   parameter int PIX_W      = 11,
   parameter int H_W        = 11,
   parameter int V_W        = 10,
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 320,
   parameter int ROOT_A     = 320,
   parameter int ROOT_B     = 120,
   parameter int PHASE_STEP = 4
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             data_valid_in,
   input  logic [PIX_W-1:0] pixel_in,
   input  logic [H_W-1:0]   hcount_in,
   input  logic [V_W-1:0]   vcount_in,
   input  logic [1:0]       mode_in,
   input  logic [2:0]       amp_shift_in,
   input  logic             frame_done_in,
   output logic             data_valid_out,
   output logic [PIX_W-1:0] pixel_out,
   output logic [H_W-1:0]   hcount_out,
   output logic [V_W-1:0]   vcount_out
);

   localparam int C = coord_w(H_W, V_W);

   // Stream contract: a beat is accepted on every cycle data_valid_in is high (no ready);
   // it emerges exactly three cycles later with data_valid_out high, all fields zero otherwise.

   warp_mode_e          mode_d;
   logic [C-1:0]        u_d, mod_d, phase_cur;
   logic signed [C-1:0] pc;

   assign mode_d = warp_mode_e'(mode_in);
   assign u_d    = (mode_d == WARP_HORZ) ? C'(vcount_in) : C'(hcount_in);
   assign mod_d  = (mode_d == WARP_HORZ) ? C'(WIDTH) : C'(HEIGHT);

`ifdef WAVE_WARP_ANIM_EN
   logic [C-1:0] phase_q, phase_d;
   int           ph_sum;

   always_comb begin
      ph_sum  = int'(phase_q) + PHASE_STEP;
      phase_d = C'((mode_d == WARP_HORZ) ? (ph_sum % WIDTH) : (ph_sum % HEIGHT));
   end

   always_ff @(posedge clk_in) begin
      if (rst_in)
         phase_q <= '0;
      else if (frame_done_in)
         phase_q <= phase_d;
   end

   assign phase_cur = phase_q;
`else
   logic unused_frame_done;
   assign unused_frame_done = frame_done_in;
   assign phase_cur         = '0;
`endif

   wave_warp_poly #(
      .C      (C),
      .ROOT_A (ROOT_A),
      .ROOT_B (ROOT_B)
   ) u_poly (
      .clk_i   (clk_in),
      .rst_i   (rst_in),
      .u_i     (u_d),
      .shift_i (amp_shift_in),
      .mod_i   (mod_d),
      .pc_o    (pc)
   );

   logic             s1_valid_q, s2_valid_q, valid_q;
   logic [PIX_W-1:0] s1_pixel_q, s2_pixel_q, pixel_q;
   logic [H_W-1:0]   s1_h_q, s2_h_q, h_q, h_d;
   logic [V_W-1:0]   s1_v_q, s2_v_q, v_q, v_d;
   warp_mode_e       s1_mode_q, s2_mode_q;
   logic [C-1:0]     s1_phase_q, s2_phase_q;

   int w_s, m_s, raw_s, res_s;

   // Stage 3: add, wrap; a warped coordinate already outside the frame is left alone.
   always_comb begin
      h_d = s2_h_q;
      v_d = s2_v_q;
      if (s2_mode_q == WARP_VERT) begin
         w_s = int'(s2_v_q);
         m_s = HEIGHT;
      end else begin
         w_s = int'(s2_h_q);
         m_s = WIDTH;
      end
      raw_s = w_s + int'(pc) + int'(s2_phase_q);
      res_s = wrap_coord(raw_s, m_s);
      if ((s2_mode_q == WARP_VERT) && (w_s < m_s))
         v_d = V_W'(res_s);
      else if ((s2_mode_q == WARP_HORZ) && (w_s < m_s))
         h_d = H_W'(res_s);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         s1_valid_q <= 1'b0;
         s1_pixel_q <= '0;
         s1_h_q     <= '0;
         s1_v_q     <= '0;
         s1_mode_q  <= WARP_BYPASS;
         s1_phase_q <= '0;
         s2_valid_q <= 1'b0;
         s2_pixel_q <= '0;
         s2_h_q     <= '0;
         s2_v_q     <= '0;
         s2_mode_q  <= WARP_BYPASS;
         s2_phase_q <= '0;
         valid_q    <= 1'b0;
         pixel_q    <= '0;
         h_q        <= '0;
         v_q        <= '0;
      end else begin
         s1_valid_q <= data_valid_in;
         s1_pixel_q <= pixel_in;
         s1_h_q     <= hcount_in;
         s1_v_q     <= vcount_in;
         s1_mode_q  <= mode_d;
         s1_phase_q <= phase_cur;
         s2_valid_q <= s1_valid_q;
         s2_pixel_q <= s1_pixel_q;
         s2_h_q     <= s1_h_q;
         s2_v_q     <= s1_v_q;
         s2_mode_q  <= s1_mode_q;
         s2_phase_q <= s1_phase_q;
         valid_q    <= s2_valid_q;
         pixel_q    <= s2_valid_q ? s2_pixel_q : '0;
         h_q        <= s2_valid_q ? h_d : '0;
         v_q        <= s2_valid_q ? v_d : '0;
      end
   end

   assign data_valid_out = valid_q;
   assign pixel_out      = pixel_q;
   assign hcount_out     = h_q;
   assign vcount_out     = v_q;

endmodule

// File: tb/tb_wave_warp.sv
// Directed and randomized checks of wave_warp against an arithmetic reference model.
module tb_wave_warp;

   localparam int WIDTH  = 320;
   localparam int HEIGHT = 320;
   localparam int ROOT_A = 320;
   localparam int ROOT_B = 120;
   localparam int STEP   = 4;
   localparam int OUT_W  = 1 + 11 + 11 + 10;
`ifdef WAVE_WARP_ANIM_EN
   localparam int ANIM = 1;
`else
   localparam int ANIM = 0;
`endif

   typedef struct {
      logic        valid;
      logic [10:0] pix;
      logic [10:0] h;
      logic [9:0]  v;
      logic [1:0]  mode;
      logic [2:0]  shift;
      logic        fd;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_in;
   logic        data_valid_in;
   logic [10:0] pixel_in;
   logic [10:0] hcount_in;
   logic [9:0]  vcount_in;
   logic [1:0]  mode_in;
   logic [2:0]  amp_shift_in;
   logic        frame_done_in;
   logic        data_valid_out;
   logic [10:0] pixel_out;
   logic [10:0] hcount_out;
   logic [9:0]  vcount_out;

   logic [OUT_W-1:0] exp_q[$];
   string            tag_q[$];
   int               checks   = 0;
   int               failures = 0;
   int               model_phase = 0;

   always #5 clk = ~clk;

   wave_warp dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .data_valid_in  (data_valid_in),
      .pixel_in       (pixel_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .mode_in        (mode_in),
      .amp_shift_in   (amp_shift_in),
      .frame_done_in  (frame_done_in),
      .data_valid_out (data_valid_out),
      .pixel_out      (pixel_out),
      .hcount_out     (hcount_out),
      .vcount_out     (vcount_out)
   );

   function automatic longint fdiv(input longint a, input longint d);
      return (a >= 0) ? (a / d) : -((-a + d - 1) / d);
   endfunction

   function automatic beat_t mk(input logic valid, input logic [10:0] pix, input int h, input int v,
                                input int mode, input int shift, input logic fd);
      beat_t       b;
      logic [31:0] t;
      b.valid = valid;
      b.pix   = pix;
      t = h;     b.h     = t[10:0];
      t = v;     b.v     = t[9:0];
      t = mode;  b.mode  = t[1:0];
      t = shift; b.shift = t[2:0];
      b.fd = fd;
      return b;
   endfunction

   function automatic logic [OUT_W-1:0] pk(input logic [10:0] pix, input int h, input int v);
      logic [31:0] th, tv;
      th = h;
      tv = v;
      return {1'b1, pix, th[10:0], tv[9:0]};
   endfunction

   // Reference: plain integer arithmetic, floor division for the shifts, modulo for the wrap.
   function automatic logic [OUT_W-1:0] model(input beat_t b, input int phase);
      int          u, w, m, res;
      longint      p, lim;
      logic [31:0] r32;
      logic [10:0] ho;
      logic [9:0]  vo;
      if (!b.valid) return '0;
      ho = b.h;
      vo = b.v;
      if (b.mode == 2'd1 || b.mode == 2'd2) begin
         if (b.mode == 2'd1) begin
            u = int'(b.h); w = int'(b.v); m = HEIGHT;
         end else begin
            u = int'(b.v); w = int'(b.h); m = WIDTH;
         end
         p = fdiv(u - ROOT_A, 16) * fdiv(u - ROOT_B, 8) * fdiv(u, 16);
         p = fdiv(p, longint'(1) << b.shift);
         lim = m - 1;
         if (p > lim) p = lim;
         if (p < -lim) p = -lim;
         if (w < m) begin
            res = ((w + int'(p) + phase) % m + m) % m;
            r32 = res;
            if (b.mode == 2'd1) vo = r32[9:0];
            else ho = r32[10:0];
         end
      end
      return {1'b1, b.pix, ho, vo};
   endfunction

   function automatic logic [OUT_W-1:0] observed();
      return {data_valid_out, pixel_out, hcount_out, vcount_out};
   endfunction

   task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp_w);
      checks++;
      assert (obs === exp_w) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_w);
      end
   endtask

   task automatic drive(input beat_t b);
      data_valid_in = b.valid;
      pixel_in      = b.pix;
      hcount_in     = b.h;
      vcount_in     = b.v;
      mode_in       = b.mode;
      amp_shift_in  = b.shift;
      frame_done_in = b.fd;
   endtask

   task automatic cycle(input beat_t b, input logic [OUT_W-1:0] exp_w, input string tag);
      logic [OUT_W-1:0] e;
      string            t;
      drive(b);
      exp_q.push_back(exp_w);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      if (exp_q.size() == 3) begin
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check(t, observed(), e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(mk(1'b0, 11'h7FF, 5 + i, 9 + i, 1, 2, 1'b0), '0, "idle");
   endtask

   task automatic advance_phase(input beat_t b);
      if (ANIM != 0 && b.fd)
         model_phase = (model_phase + STEP) % ((b.mode == 2'd2) ? WIDTH : HEIGHT);
   endtask

   initial begin
      beat_t b;
      logic [OUT_W-1:0] e;

      rst_in = 1'b1;
      drive(mk(1'b0, 11'h0, 0, 0, 0, 0, 1'b0));
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", observed(), '0);
      rst_in = 1'b0;

      cycle(mk(1'b1, 11'h5A5, 17, 42, 0, 0, 1'b0), pk(11'h5A5, 17, 42), "bypass");
      idle(3);
      cycle(mk(1'b1, 11'h123, 300, 200, 3, 5, 1'b0), pk(11'h123, 300, 200), "bypass_rsvd");

      cycle(mk(1'b1, 11'h0AA, 100, 100, 1, 0, 1'b0), pk(11'h0AA, 100, 32), "vert_s0_h100");
      cycle(mk(1'b1, 11'h155, 200, 100, 1, 0, 1'b0), pk(11'h155, 200, 101), "vert_s0_clamp");
      cycle(mk(1'b1, 11'h2B7, 200, 100, 1, 3, 1'b0), pk(11'h2B7, 200, 300), "vert_s3");
      cycle(mk(1'b1, 11'h011, 100, 330, 1, 0, 1'b0), pk(11'h011, 100, 330), "vert_outside");
      cycle(mk(1'b1, 11'h3C3, 100, 100, 2, 0, 1'b0), pk(11'h3C3, 32, 100), "horz_s0");
      cycle(mk(1'b1, 11'h0F1, 400, 100, 2, 0, 1'b0), pk(11'h0F1, 400, 100), "horz_outside");
      idle(3);

      for (int i = 0; i < 4; i++) begin
         b = mk(1'b0, 11'h0, 0, 0, 1, 0, 1'b1);
         cycle(b, '0, "phase_pulse");
         advance_phase(b);
      end
      b = mk(1'b1, 11'h0F0, 0, 310, 1, 0, 1'b1);
      cycle(b, pk(11'h0F0, 0, (310 + ANIM * 16) % 320), "phase_16_same_cycle");
      advance_phase(b);
      cycle(mk(1'b1, 11'h0F0, 0, 310, 1, 0, 1'b0), pk(11'h0F0, 0, (310 + ANIM * 20) % 320), "phase_20");
      idle(3);

      for (int i = 0; i < 400; i++) begin
         b.valid = ($urandom_range(0, 3) != 0);
         b.pix   = 11'($urandom_range(0, 2047));
         b.h     = 11'($urandom_range(0, 400));
         b.v     = 10'($urandom_range(0, 340));
         b.mode  = 2'($urandom_range(0, 3));
         b.shift = 3'($urandom_range(0, 7));
         b.fd    = ($urandom_range(0, 7) == 0);
         e = model(b, model_phase);
         cycle(b, e, "random");
         advance_phase(b);
      end
      idle(3);

      for (int i = 0; i < 3; i++) begin
         b = mk(1'b1, 11'h200, 50 + i, 60 + i, 1, 1, 1'b1);
         e = model(b, model_phase);
         cycle(b, e, "pre_reset");
         advance_phase(b);
      end
      rst_in = 1'b1;
      drive(mk(1'b0, 11'h0, 0, 0, 1, 0, 1'b0));
      @(posedge clk);
      #1;
      rst_in = 1'b0;
      exp_q.delete();
      tag_q.delete();
      model_phase = 0;
      check("reset_flush_0", observed(), '0);
      for (int i = 1; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_flush", observed(), '0);
      end
      cycle(mk(1'b1, 11'h0F0, 0, 310, 1, 0, 1'b0), pk(11'h0F0, 0, 310), "post_reset_phase");
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wave_warp.md
# wave_warp

Parametrised, pipelined geometric warp stage for the pixel-stream filter chain. Displaces each pixel's vertical (or horizontal) coordinate by a cubic polynomial of the other coordinate, with a programmable amplitude and an optional per-frame animated phase. The result wraps modulo the frame dimension. Sits between the camera/frame-buffer read path and the display compositor, and carries pixel data through untouched.

## Interface
Parameters:
- PIX_W, 11: pixel data width
- H_W, 11: hcount width
- V_W, 10: vcount width
- WIDTH, 320: active frame width; horizontal wrap modulus
- HEIGHT, 320: active frame height; vertical wrap modulus
- ROOT_A, 320: first polynomial root
- ROOT_B, 120: second polynomial root
- PHASE_STEP, 4: phase increment per frame

Ports:
- clk_in, input, 1: sole clock
- rst_in, input, 1: synchronous, active-high reset
- data_valid_in, input, 1: beat qualifier
- pixel_in, input, PIX_W: pixel data
- hcount_in, input, H_W: pixel column
- vcount_in, input, V_W: pixel row
- mode_in, input, 2: 0 = bypass, 1 = vertical warp, 2 = horizontal warp, 3 = reserved (treated as bypass)
- amp_shift_in, input, 3: arithmetic right shift applied to the polynomial
- frame_done_in, input, 1: one-cycle end-of-frame pulse
- data_valid_out, output, 1: delayed valid
- pixel_out, output, PIX_W: delayed pixel
- hcount_out, output, H_W: warped or delayed column
- vcount_out, output, V_W: warped or delayed row

## Operation
- Driver coordinate u: hcount in mode 1, vcount in mode 2. Warped coordinate w: the other one. Modulus M: HEIGHT in mode 1, WIDTH in mode 2.
- Signed internal width C = max(H_W,V_W)+2. Factors: fa = (u−ROOT_A)>>>4, fb = (u−ROOT_B)>>>3, fc = u>>>4. All shifts are arithmetic and floor toward −∞.
- Product: p = (fa·fb·fc) >>> amp_shift_in, computed at 3·C bits. pc = clamp(p, −(M−1), M−1).
- raw = w + pc + phase. Wrap rule:
  - raw < 0: raw + M
  - raw ≥ 2M: raw − 2M
  - raw ≥ M: raw − M
  - otherwise: raw
- Result is always in [0, M−1].
- If w ≥ M on input, the coordinate passes through unmodified.
- The other coordinate and the pixel are always passed through unmodified.
- Bypass modes (0, 3): all fields delayed only.
- mode_in and amp_shift_in are sampled with each beat at stage 1 and travel with it; a change mid-frame affects only later beats.
- phase register, range [0, max(WIDTH,HEIGHT)−1]:
  - On frame_done_in: phase ← (phase + PHASE_STEP) mod HEIGHT in mode-1 frames.
  - The modulus is selected by the mode_in value present at the pulse.
  - The new phase applies to beats entering stage 1 on the following cycle.
  - A beat entering in the same cycle as the pulse uses the old phase.
- Output fields are 0 whenever data_valid_out is 0.

## Timing
- Fixed latency 3 cycles, throughput 1 beat/cycle, no backpressure.
  - Stage 1: register inputs and compute the factors.
  - Stage 2: product, shift, clamp.
  - Stage 3: add, wrap, register outputs.
- Reset:
  - All pipeline valids and outputs are 0 on the cycle after rst_in is sampled high; phase is 0.
  - In-flight beats are discarded.
  - The first valid output appears 3 cycles after the first beat accepted post-reset.
- A bubble (data_valid_in = 0) propagates as a bubble 3 cycles later.

## Configuration
- WAVE_WARP_ANIM_EN defined: the phase register and frame_done_in logic are compiled in, as described.
- Undefined: phase is the constant 0, frame_done_in is ignored, and no phase register is generated.

## Structure
- Package wave_warp_pkg holds:
  - the mode typedef enum (WARP_BYPASS, WARP_VERT, WARP_HORZ, WARP_RSVD)
  - localparam helpers for C and the product width
  - the wrap function
- One sub-module, wave_warp_poly: stages 1–2. Input u plus the shift; output pc, clamped to a modulus input. It is instantiated once, with the driver-coordinate mux in front of it.

## Test plan
- Bypass: mode 0, pixel 0x5A5, h=17, v=42 -> identical values with valid exactly 3 cycles later; fields 0 on idle cycles.
- Vertical, shift 0, phase 0:
  - h=100, v=100 -> p=252, vcount_out=32.
  - h=200, v=100 -> p=−960, clamped to −319, vcount_out=101.
- Vertical, shift 3: h=200, v=100 -> p=−120, vcount_out=300. hcount_out=200 and pixel are unchanged.
- Phase (ANIM_EN, PHASE_STEP=4): four frame_done pulses in mode 1 -> phase 16. Then h=0, v=310 -> vcount_out=6. Without the macro -> 310.
- Horizontal: mode 2, v=100, h=100, shift 0 -> hcount_out=32, vcount_out=100. With h=400 (≥ WIDTH) -> h passes through as 400.
- Reset mid-stream: 3 valid beats in flight, then rst_in high for 1 cycle -> data_valid_out=0 on the following 3 cycles and phase=0.
